// File: rtl/overload_frame_if.sv
// overload_frame_if
//  Bundles the bus-side and interframe-space-side signals of the overload
//  frame block.
//  slave  : the overload_frame block itself. It receives canRX and isOverload
//           and drives every status output.
//  master : the environment, i.e. the bus model or the interframe-space stage.
//  Signals:
//    canRX         sampled bus level (0 = dominant)
//    isOverload    overload request from the interframe-space stage
//    canTX         driven bus level (1 = recessive/idle)
//    endOverload   1-cycle pulse when the overload frame completes cleanly
//    overloadBusy  high while a frame is in progress
//    overloadCount number of frames in the current chain, saturating at 3
//    bitError      1-cycle pulse: recessive read while driving dominant
//    formError     1-cycle pulse: dominant bit inside the delimiter
//    stuckError    1-cycle pulse: too many dominant bits after the own flag
interface overload_frame_if;
    logic       canRX;
    logic       isOverload;
    logic       canTX;
    logic       endOverload;
    logic       overloadBusy;
    logic [1:0] overloadCount;
    logic       bitError;
    logic       formError;
    logic       stuckError;

    modport slave (
        input  canRX,
        input  isOverload,
        output canTX,
        output endOverload,
        output overloadBusy,
        output overloadCount,
        output bitError,
        output formError,
        output stuckError
    );

    modport master (
        output canRX,
        output isOverload,
        input  canTX,
        input  endOverload,
        input  overloadBusy,
        input  overloadCount,
        input  bitError,
        input  formError,
        input  stuckError
    );
endinterface

// File: rtl/overload_frame.sv
// overload_frame
//  Transmits the CAN overload flag when the interframe-space stage requests
//  it. The block tolerates flag superposition from other nodes, checks the
//  overload delimiter, and then pulses endOverload. A dominant level on the
//  last delimiter bit starts a chained overload frame. Bit, form and stuck
//  errors are reported as 1-cycle pulses. One bit is processed per
//  samplePoint rising edge, and every output is registered.
//  Ports:
//    samplePoint  bit clock; one rising edge per sampled bit
//    reset        synchronous, active-high; releases the bus immediately
//    bus          overload_frame_if.slave (see the interface for its signals)
module overload_frame #(
    parameter int FLAG_LEN  = 6,
    parameter int DELIM_LEN = 8,
    parameter int DOM_LIMIT = 14
) (
    input  logic             samplePoint,
    input  logic             reset,
    overload_frame_if.slave  bus
);
    localparam int FLAG_W  = $clog2(FLAG_LEN + 1);
    localparam int DELIM_W = $clog2(DELIM_LEN + 1);
    localparam int DOM_W   = $clog2(DOM_LIMIT + 1);

    // Counter values seen on the edge that completes each phase
    localparam logic [FLAG_W-1:0]  FLAG_LAST  = FLAG_W'(FLAG_LEN - 1);
    localparam logic [DELIM_W-1:0] DELIM_LAST = DELIM_W'(DELIM_LEN - 1);
    localparam logic [DOM_W-1:0]   DOM_LAST   = DOM_W'(DOM_LIMIT - 1);

    typedef enum logic [1:0] {IDLE, FLAG, WAIT_REC, DELIM} state_t;

    state_t             state, stateNext;
    logic [FLAG_W-1:0]  flagCnt, flagCntNext;
    logic [DOM_W-1:0]   domCnt, domCntNext;
    logic [DELIM_W-1:0] delimCnt, delimCntNext;
    logic [1:0]         count, countNext;
    logic               canTx, canTxNext;
    logic               busy;
    logic               endPulse, endNext;
    logic               bitErr, bitErrNext;
    logic               formErr, formErrNext;
    logic               stuckErr, stuckErrNext;

    always_comb begin
        stateNext    = state;
        flagCntNext  = flagCnt;
        domCntNext   = domCnt;
        delimCntNext = delimCnt;
        countNext    = count;
        canTxNext    = canTx;
        endNext      = 1'b0;
        bitErrNext   = 1'b0;
        formErrNext  = 1'b0;
        stuckErrNext = 1'b0;
        case (state)
            IDLE: begin
                if (bus.isOverload) begin
                    stateNext   = FLAG;
                    canTxNext   = 1'b0;
                    flagCntNext = '0;
                    countNext   = 2'd1;
                end
            end
            FLAG: begin
                if (bus.canRX) begin
                    // Recessive read while we drive dominant: abandon the frame
                    bitErrNext = 1'b1;
                    canTxNext  = 1'b1;
                    stateNext  = IDLE;
                end else begin
                    flagCntNext = flagCnt + FLAG_W'(1);
                    if (flagCnt == FLAG_LAST) begin
                        stateNext  = WAIT_REC;
                        canTxNext  = 1'b1;
                        domCntNext = '0;
                    end
                end
            end
            WAIT_REC: begin
                if (bus.canRX) begin
                    // This recessive bit is already the first delimiter bit
                    stateNext    = DELIM;
                    delimCntNext = DELIM_W'(1);
                end else if (domCnt == DOM_LAST) begin
                    stuckErrNext = 1'b1;
                    domCntNext   = '0;
                end else begin
                    domCntNext = domCnt + DOM_W'(1);
                end
            end
            DELIM: begin
                if (bus.canRX) begin
                    delimCntNext = delimCnt + DELIM_W'(1);
                    if (delimCnt == DELIM_LAST) begin
                        stateNext = IDLE;
                        endNext   = 1'b1;
                    end
                end else if (delimCnt == DELIM_LAST) begin
                    // Dominant on the last delimiter bit chains a new overload frame
                    stateNext   = FLAG;
                    canTxNext   = 1'b0;
                    flagCntNext = '0;
                    countNext   = (count == 2'd3) ? 2'd3 : count + 2'd1;
                end else begin
                    formErrNext = 1'b1;
                    stateNext   = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                canTxNext = 1'b1;
            end
        endcase
    end

    always_ff @(posedge samplePoint) begin
        if (reset) begin
            state    <= IDLE;
            flagCnt  <= '0;
            domCnt   <= '0;
            delimCnt <= '0;
            count    <= 2'd0;
            canTx    <= 1'b1;
            busy     <= 1'b0;
            endPulse <= 1'b0;
            bitErr   <= 1'b0;
            formErr  <= 1'b0;
            stuckErr <= 1'b0;
        end else begin
            state    <= stateNext;
            flagCnt  <= flagCntNext;
            domCnt   <= domCntNext;
            delimCnt <= delimCntNext;
            count    <= countNext;
            canTx    <= canTxNext;
            busy     <= (stateNext != IDLE);
            endPulse <= endNext;
            bitErr   <= bitErrNext;
            formErr  <= formErrNext;
            stuckErr <= stuckErrNext;
        end
    end

    assign bus.canTX         = canTx;
    assign bus.endOverload   = endPulse;
    assign bus.overloadBusy  = busy;
    assign bus.overloadCount = count;
    assign bus.bitError      = bitErr;
    assign bus.formError     = formErr;
    assign bus.stuckError    = stuckErr;
endmodule
